// File: rtl/jtframe_dump_ctrl.sv
// Frame-counting capture-window controller: opens an N-frame dump window on a frame number or download end.
// Optional macro JTFRAME_DUMP_SYNC_EN adds 2-flop synchronisers on vs/led, adding 2 clk of edge latency.
module jtframe_dump_ctrl #(
  parameter int CW      = 32,
  parameter int CH      = 4,
  parameter int HOLDOFF = 20000
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          vs,
  input  logic          led,
  input  logic          arm,
  input  logic          abort,
  input  logic          mode,
  input  logic [CW-1:0] start_frame,
  input  logic [CW-1:0] len_frames,
  input  logic [CH-1:0] ch_mask,
  output logic [CW-1:0] frame_cnt,
  output logic [CH-1:0] dump_en,
  output logic          dump_on,
  output logic          dump_off,
  output logic          busy,
  output logic          done
);
  localparam int            HW       = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLDOFF);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DUMPING, S_DONE} state_t;

  state_t        state_q, state_d;
  logic          vs_i, led_i;
  logic          vs_l_q, led_l_q;
  logic          vs_fall, led_fall;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          hold_ok;
  logic [CW-1:0] frame_cnt_q, frame_cnt_d;
  logic          mode_q, mode_d;
  logic [CW-1:0] start_q, start_d;
  logic [CW-1:0] len_q, len_d;
  logic [CH-1:0] mask_q, mask_d;
  logic [CW-1:0] rem_q, rem_d;
  logic          arm_ok, trig, close;
  logic [CH-1:0] dump_en_q, dump_en_d;
  logic          dump_on_q, dump_on_d;
  logic          dump_off_q, dump_off_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

`ifdef JTFRAME_DUMP_SYNC_EN
  logic [1:0] vs_sync_q, led_sync_q;

  // Synchronisers reset to the idle levels so reset release never looks like an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_sync_q  <= 2'b11;
      led_sync_q <= 2'b00;
    end else begin
      vs_sync_q  <= {vs_sync_q[0], vs};
      led_sync_q <= {led_sync_q[0], led};
    end
  end

  assign vs_i  = vs_sync_q[1];
  assign led_i = led_sync_q[1];
`else
  assign vs_i  = vs;
  assign led_i = led;
`endif

  assign vs_fall  = vs_l_q & ~vs_i;
  assign led_fall = led_l_q & ~led_i;
  assign hold_ok  = (hold_cnt_q == HOLD_MAX);

  assign arm_ok = arm && ((state_q == S_IDLE) || (state_q == S_DONE));
  // Frame trigger compares against the count before this fall increments it
  assign trig   = (state_q == S_ARMED) &&
                  ((!mode_q && vs_fall && (frame_cnt_q == start_q)) ||
                   ( mode_q && led_fall && hold_ok));
  assign close  = (state_q == S_DUMPING) && vs_fall && (rem_q == CW'(1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: abort beats trigger/close, which beat arm
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (arm) state_d = S_ARMED;
      S_ARMED: begin
        if (abort)     state_d = S_IDLE;
        else if (trig) state_d = S_DUMPING;
      end
      S_DUMPING: begin
        if (abort)      state_d = S_IDLE;
        else if (close) state_d = S_DONE;
      end
      S_DONE:    if (arm) state_d = S_ARMED;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output logic, registered below so every output changes on the deciding edge
  always_comb begin
    dump_on_d  = (state_q == S_ARMED) && (state_d == S_DUMPING);
    dump_off_d = (state_q == S_DUMPING) && (state_d != S_DUMPING);
    dump_en_d  = dump_en_q;
    if (dump_on_d)       dump_en_d = mask_q;
    else if (dump_off_d) dump_en_d = '0;
    busy_d     = (state_d == S_ARMED) || (state_d == S_DUMPING);
    done_d     = (state_d == S_DONE);
  end

  always_comb begin
    frame_cnt_d = vs_fall ? frame_cnt_q + CW'(1) : frame_cnt_q;
    hold_cnt_d  = hold_ok ? hold_cnt_q : hold_cnt_q + HW'(1);
    mode_d      = arm_ok ? mode        : mode_q;
    start_d     = arm_ok ? start_frame : start_q;
    len_d       = arm_ok ? len_frames  : len_q;
    mask_d      = arm_ok ? ch_mask     : mask_q;
    rem_d       = rem_q;
    // A zero length never decrements, keeping the window open until abort
    if (dump_on_d)
      rem_d = len_q;
    else if ((state_q == S_DUMPING) && vs_fall && (rem_q != '0))
      rem_d = rem_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_l_q      <= 1'b1;
      led_l_q     <= 1'b0;
      hold_cnt_q  <= '0;
      frame_cnt_q <= '0;
      mode_q      <= 1'b0;
      start_q     <= '0;
      len_q       <= '0;
      mask_q      <= '0;
      rem_q       <= '0;
      dump_en_q   <= '0;
      dump_on_q   <= 1'b0;
      dump_off_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      vs_l_q      <= vs_i;
      led_l_q     <= led_i;
      hold_cnt_q  <= hold_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      mode_q      <= mode_d;
      start_q     <= start_d;
      len_q       <= len_d;
      mask_q      <= mask_d;
      rem_q       <= rem_d;
      dump_en_q   <= dump_en_d;
      dump_on_q   <= dump_on_d;
      dump_off_q  <= dump_off_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign dump_en   = dump_en_q;
  assign dump_on   = dump_on_q;
  assign dump_off  = dump_off_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_jtframe_dump_ctrl.sv
// Directed bench for jtframe_dump_ctrl: frame trigger, download trigger, abort races, wrap, async reset.
// Works with or without JTFRAME_DUMP_SYNC_EN; edge responses are expected LAT clk later when defined.
module tb_jtframe_dump_ctrl;
  localparam int CW = 4;
  localparam int CH = 4;
  localparam int HOLDOFF = 100;
`ifdef JTFRAME_DUMP_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic          rst, clk, vs, led, arm, abort, mode;
  logic [CW-1:0] start_frame, len_frames;
  logic [CH-1:0] ch_mask;
  logic [CW-1:0] frame_cnt;
  logic [CH-1:0] dump_en;
  logic          dump_on, dump_off, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  jtframe_dump_ctrl #(.CW(CW), .CH(CH), .HOLDOFF(HOLDOFF)) dut (
    .rst(rst), .clk(clk), .vs(vs), .led(led), .arm(arm), .abort(abort),
    .mode(mode), .start_frame(start_frame), .len_frames(len_frames),
    .ch_mask(ch_mask), .frame_cnt(frame_cnt), .dump_en(dump_en),
    .dump_on(dump_on), .dump_off(dump_off), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic reset_dut();
    rst = 1'b1; vs = 1'b1; led = 1'b0; arm = 1'b0; abort = 1'b0;
    mode = 1'b0; start_frame = '0; len_frames = '0; ch_mask = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic arm_cfg(input logic m, input logic [CW-1:0] sf,
                         input logic [CW-1:0] len, input logic [CH-1:0] mask);
    @(negedge clk);
    mode = m; start_frame = sf; len_frames = len; ch_mask = mask; arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  // One vs fall; samples just before and at the expected response edge, then one edge later
  task automatic vs_pulse(output logic on, output logic off, output logic [CH-1:0] en,
                          output logic [CW-1:0] fc_pre, output logic [CW-1:0] fc,
                          output logic on_nx, output logic off_nx);
    @(negedge clk);
    vs = 1'b0;
    repeat (LAT) @(posedge clk);
    #1 fc_pre = frame_cnt;
    @(posedge clk);
    #1 on = dump_on; off = dump_off; en = dump_en; fc = frame_cnt;
    @(posedge clk);
    #1 on_nx = dump_on; off_nx = dump_off;
    @(negedge clk);
    vs = 1'b1;
    repeat (LAT + 2) @(negedge clk);
  endtask

  task automatic led_pulse(output logic on, output logic [CH-1:0] en, output logic on_nx);
    @(negedge clk);
    led = 1'b1;
    repeat (LAT + 2) @(negedge clk);
    led = 1'b0;
    repeat (LAT + 1) @(posedge clk);
    #1 on = dump_on; en = dump_en;
    @(posedge clk);
    #1 on_nx = dump_on;
  endtask

  task automatic test_reset();
    reset_dut();
    #1;
    n_cmp++;
    if ({frame_cnt, dump_en, dump_on, dump_off, busy, done} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got fc=%0d en=%b on=%b off=%b busy=%b done=%b, want all 0",
               frame_cnt, dump_en, dump_on, dump_off, busy, done);
    end
  endtask

  task automatic test_frame_trigger();
    logic on, off, on_nx, off_nx;
    logic [CH-1:0] en;
    logic [CW-1:0] fc_pre, fc;
    logic [13:0] got, exp_v;
    reset_dut();
    arm_cfg(1'b0, 4'd5, 4'd3, 4'b1010);
    n_cmp++;
    if ({busy, done} !== 2'b10) begin
      n_err++; $display("FAIL arm_busy: got busy=%b done=%b, want 1 0", busy, done);
    end
    // A second arm with a different config while ARMED must be ignored
    arm_cfg(1'b1, 4'd0, 4'd1, 4'b1111);
    for (int i = 1; i <= 10; i++) begin
      vs_pulse(on, off, en, fc_pre, fc, on_nx, off_nx);
      got   = {on, off, en, fc_pre, fc};
      exp_v = {(i == 6), (i == 9), ((i >= 6) && (i < 9)) ? 4'b1010 : 4'b0000,
               4'(i - 1), 4'(i)};
      n_cmp++;
      if (got !== exp_v) begin
        n_err++;
        $display("FAIL frame_trig_f%0d: got on/off/en/pre/fc=%b, want %b", i, got, exp_v);
      end
      n_cmp++;
      if ({on_nx, off_nx} !== 2'b00) begin
        n_err++;
        $display("FAIL frame_trig_width_f%0d: got on/off one cycle later=%b%b, want 00", i, on_nx, off_nx);
      end
    end
    n_cmp++;
    if ({busy, done} !== 2'b01) begin
      n_err++; $display("FAIL frame_trig_done: got busy=%b done=%b, want 0 1", busy, done);
    end
    arm_cfg(1'b0, 4'd0, 4'd1, 4'b0001);
    n_cmp++;
    if ({busy, done} !== 2'b10) begin
      n_err++; $display("FAIL rearm_from_done: got busy=%b done=%b, want 1 0", busy, done);
    end
  endtask

  task automatic test_download_trigger();
    logic on, off, on_nx, off_nx;
    logic [CH-1:0] en;
    logic [CW-1:0] fc_pre, fc;
    reset_dut();
    repeat (40) @(negedge clk);
    arm_cfg(1'b1, 4'd0, 4'd0, 4'b0110);
    led_pulse(on, en, on_nx);
    n_cmp++;
    if ({on, en, busy} !== {1'b0, 4'b0000, 1'b1}) begin
      n_err++;
      $display("FAIL led_before_holdoff: got on=%b en=%b busy=%b, want 0 0000 1", on, en, busy);
    end
    @(negedge clk);
    led = 1'b1;
    repeat (140) @(negedge clk);
    led_pulse(on, en, on_nx);
    n_cmp++;
    if ({on, en, on_nx} !== {1'b1, 4'b0110, 1'b0}) begin
      n_err++;
      $display("FAIL led_trigger: got on=%b en=%b on_next=%b, want 1 0110 0", on, en, on_nx);
    end
    for (int i = 1; i <= 20; i++) begin
      vs_pulse(on, off, en, fc_pre, fc, on_nx, off_nx);
      n_cmp++;
      if ({on, off, en, busy, fc} !== {1'b0, 1'b0, 4'b0110, 1'b1, 4'(i)}) begin
        n_err++;
        $display("FAIL unbounded_f%0d: got on=%b off=%b en=%b busy=%b fc=%0d, want 0 0 0110 1 %0d",
                 i, on, off, en, busy, fc, i % 16);
      end
    end
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({dump_off, dump_en, busy, done} !== {1'b1, 4'b0000, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL abort_window: got off=%b en=%b busy=%b done=%b, want 1 0000 0 0",
               dump_off, dump_en, busy, done);
    end
    @(negedge clk);
    abort = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (dump_off !== 1'b0) begin
      n_err++; $display("FAIL abort_off_width: got off=%b one cycle later, want 0", dump_off);
    end
  endtask

  task automatic test_abort_on_trigger();
    logic on, off, on_nx, off_nx;
    logic [CH-1:0] en;
    logic [CW-1:0] fc_pre, fc;
    reset_dut();
    arm_cfg(1'b0, 4'd2, 4'd3, 4'b1111);
    vs_pulse(on, off, en, fc_pre, fc, on_nx, off_nx);
    vs_pulse(on, off, en, fc_pre, fc, on_nx, off_nx);
    @(negedge clk);
    vs = 1'b0;
    repeat (LAT) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({dump_on, dump_en, busy, frame_cnt} !== {1'b0, 4'b0000, 1'b0, 4'd3}) begin
      n_err++;
      $display("FAIL abort_vs_trigger: got on=%b en=%b busy=%b fc=%0d, want 0 0000 0 3",
               dump_on, dump_en, busy, frame_cnt);
    end
    @(negedge clk);
    abort = 1'b0; vs = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({dump_on, busy, done} !== 3'b000) begin
      n_err++;
      $display("FAIL abort_vs_trigger_after: got on=%b busy=%b done=%b, want 000", dump_on, busy, done);
    end
  endtask

  task automatic test_wrap();
    logic on, off, on_nx, off_nx;
    logic [CH-1:0] en;
    logic [CW-1:0] fc_pre, fc;
    logic [13:0] got, exp_v;
    reset_dut();
    repeat (9) vs_pulse(on, off, en, fc_pre, fc, on_nx, off_nx);
    n_cmp++;
    if (frame_cnt !== 4'd9) begin
      n_err++; $display("FAIL wrap_preload: got fc=%0d, want 9", frame_cnt);
    end
    arm_cfg(1'b0, 4'd2, 4'd1, 4'b0001);
    for (int i = 1; i <= 11; i++) begin
      vs_pulse(on, off, en, fc_pre, fc, on_nx, off_nx);
      got   = {on, off, en, fc_pre, fc};
      exp_v = {(i == 10), (i == 11), (i == 10) ? 4'b0001 : 4'b0000,
               4'((8 + i) % 16), 4'((9 + i) % 16)};
      n_cmp++;
      if (got !== exp_v) begin
        n_err++;
        $display("FAIL wrap_f%0d: got on/off/en/pre/fc=%b, want %b", i, got, exp_v);
      end
    end
    n_cmp++;
    if ({busy, done} !== 2'b01) begin
      n_err++; $display("FAIL wrap_done: got busy=%b done=%b, want 0 1", busy, done);
    end
  endtask

  task automatic test_reset_mid_window();
    logic on, off, on_nx, off_nx;
    logic [CH-1:0] en;
    logic [CW-1:0] fc_pre, fc;
    reset_dut();
    arm_cfg(1'b0, 4'd0, 4'd0, 4'b1111);
    vs_pulse(on, off, en, fc_pre, fc, on_nx, off_nx);
    n_cmp++;
    if ({on, en} !== 5'b11111) begin
      n_err++; $display("FAIL midrst_open: got on=%b en=%b, want 1 1111", on, en);
    end
    vs_pulse(on, off, en, fc_pre, fc, on_nx, off_nx);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({frame_cnt, dump_en, dump_on, dump_off, busy, done} !== '0) begin
      n_err++;
      $display("FAIL midrst_async_clear: got fc=%0d en=%b on=%b off=%b busy=%b done=%b, want all 0",
               frame_cnt, dump_en, dump_on, dump_off, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if ({dump_off, dump_en, busy} !== 6'b0) begin
        n_err++;
        $display("FAIL midrst_no_off_c%0d: got off=%b en=%b busy=%b, want 0 0000 0", i, dump_off, dump_en, busy);
      end
    end
    vs_pulse(on, off, en, fc_pre, fc, on_nx, off_nx);
    n_cmp++;
    if ({fc, on, off} !== {4'd1, 2'b00}) begin
      n_err++; $display("FAIL midrst_next_frame: got fc=%0d on=%b off=%b, want 1 0 0", fc, on, off);
    end
  endtask

  initial begin
    test_reset();
    test_frame_trigger();
    test_download_trigger();
    test_abort_on_trigger();
    test_wrap();
    test_reset_mid_window();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
